// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared encodings and defaults for timer_arbiter
//
// Purpose: FSM state encoding and default sizing used by the interface,
// the counter and the arbiter top.
package timer_arbiter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_arbiter_if.sv
// rtl/timer_arbiter_if.sv - request/grant bundle between channel logic and timer_arbiter
//
// Purpose: groups the requester-facing signals of timer_arbiter.
// Ports (signals):
//   req   - per-requester request level
//   len   - packed lengths, requester i uses len[i*CW +: CW]
//   grant - one-hot counter owner
//   done  - one-cycle completion pulse to the owner
//   busy  - counter is counting for its owner
//   cnt   - current count of the shared counter
// Modports: master = requester side, slave = arbiter side.
interface timer_arbiter_if
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      cnt;

    modport master (
        output req, len,
        input  grant, done, busy, cnt
    );

    modport slave (
        input  req, len,
        output grant, done, busy, cnt
    );

endinterface

// File: rtl/period_counter.sv
// rtl/period_counter.sv - modulo counter with synchronous clear and runtime max
//
// Purpose: counts 0..max-1 while enabled and wraps to 0.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear (wins over en)
//   en       - advance the count this edge
//   max      - modulus
//   cnt      - registered count
//   wrap     - cnt == max-1
module period_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] max,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Full-width compare so max = 2^CW-1 wraps at 2^CW-2.
    assign wrap = (cnt_q == (max - CW'(1)));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin owner selection for one shared period counter
//
// Purpose: grants the shared counter to one requester at a time, lets it
// count 0..L-1, then pulses done to that requester and releases the counter.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of timer_arbiter_if (req/len in, grant/done/busy/cnt out)
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    timer_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   len_q,   len_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_wrap;
    logic [IW-1:0]   pick;
    logic [CW-1:0]   pick_len;

    // First set request scanning last+1, last+2, ... modulo NREQ.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign pick     = rr_pick(bus.req, last_q);
    assign pick_len = bus.len[int'(pick)*CW +: CW];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                grant_d = '0;
                if (|bus.req) begin
                    owner_d = pick;
                    grant_d = NREQ'(1) << pick;
                    len_d   = pick_len;
                    // A zero length skips counting but still holds grant
                    // for the DONE cycle so done follows grant.
                    state_d = (pick_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.req[owner_q]) begin
                    // Withdrawal: release silently, no done pulse.
                    grant_d = '0;
                    last_d  = owner_q;
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_wrap) begin
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                last_d  = owner_q;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    period_counter #(
        .CW (CW)
    ) u_period_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .max  (len_q),
        .cnt  (bus.cnt),
        .wrap (cnt_wrap)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter
module tb_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: owner plus elapsed edges since its grant.
    int              m_own;
    int              m_q;
    int              m_len;
    int              m_last;
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_done;
    logic            exp_busy;
    logic [CW-1:0]   exp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_own     = -1;
        m_q       = 0;
        m_len     = 0;
        m_last    = NREQ - 1;
        exp_grant = '0;
        exp_done  = '0;
        exp_busy  = 1'b0;
        exp_cnt   = '0;
    endtask

    function automatic int rr_first(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Expected outputs after the coming rising edge, from current inputs.
    task automatic model_edge();
        int w;
        exp_done  = '0;
        exp_grant = '0;
        exp_busy  = 1'b0;
        exp_cnt   = '0;
        if (m_own < 0) begin
            w = rr_first(bus.req, m_last);
            if (w >= 0) begin
                m_own        = w;
                m_q          = 0;
                m_len        = int'(bus.len[w*CW +: CW]);
                exp_grant[w] = 1'b1;
                exp_busy     = (m_len >= 1);
            end
        end else if (m_q < m_len && !bus.req[m_own]) begin
            m_last = m_own;
            m_own  = -1;
        end else begin
            m_q++;
            if (m_q < m_len) begin
                exp_grant[m_own] = 1'b1;
                exp_busy         = 1'b1;
                exp_cnt          = CW'(m_q);
            end else if (m_q == m_len) begin
                exp_grant[m_own] = 1'b1;
            end else begin
                exp_done[m_own] = 1'b1;
                m_last          = m_own;
                m_own           = -1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        check("grant", 64'(bus.grant), 64'(exp_grant));
        check("done",  64'(bus.done),  64'(exp_done));
        check("busy",  64'(bus.busy),  64'(exp_busy));
        check("cnt",   64'(bus.cnt),   64'(exp_cnt));
    endtask

    task automatic set_len(input int i, input int v);
        bus.len[i*CW +: CW] = CW'(v);
    endtask

    task automatic run(input int n, input bit drop_on_done);
        for (int c = 0; c < n; c++) begin
            tick();
            if (drop_on_done) bus.req = bus.req & ~exp_done;
        end
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (bus.cnt != CW'(v) && n < 40) begin
            tick();
            n++;
        end
        check("wait_cnt", 64'(bus.cnt), 64'(v));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 64'(bus.grant), 64'd0);
        check({tag, "_done"},  64'(bus.done),  64'd0);
        check({tag, "_busy"},  64'(bus.busy),  64'd0);
        check({tag, "_cnt"},   64'(bus.cnt),   64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.len = '0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single request, length 5
        set_len(0, 5);
        bus.req = 4'b0001;
        run(10, 1'b1);

        // round robin with all requests held
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        bus.req = 4'b1111;
        run(22, 1'b0);
        bus.req = '0;
        run(6, 1'b0);

        // zero length
        set_len(2, 0);
        bus.req = 4'b0100;
        run(5, 1'b1);

        // withdrawal at cnt=3, then a normal request
        set_len(1, 10);
        bus.req = 4'b0010;
        wait_cnt(3);
        bus.req = '0;
        tick();
        set_len(0, 3);
        bus.req = 4'b0001;
        run(8, 1'b1);

        // asynchronous reset mid-count
        set_len(0, 8);
        bus.req = 4'b0001;
        wait_cnt(4);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        check_zero("rst_hold");
        rst = 1'b0;
        set_len(0, 2);
        set_len(1, 2);
        bus.req = 4'b0011;
        run(12, 1'b1);

        // length latched mid-count, late arrival takes priority next
        set_len(0, 6);
        bus.req = 4'b0001;
        wait_cnt(1);
        set_len(0, 2);
        set_len(3, 3);
        bus.req = 4'b1001;
        run(16, 1'b0);
        bus.req = '0;
        run(6, 1'b0);

        // longest legal length 2^CW-1
        set_len(0, (1 << CW) - 1);
        bus.req = 4'b0001;
        run((1 << CW) + 4, 1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(5) == 0) begin
                        bus.req[i] = 1'b1;
                        set_len(i, ($urandom_range(9) == 0) ? int'($urandom_range(20))
                                                            : int'($urandom_range(6)));
                    end
                end else if (i == m_own && $urandom_range(39) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom_range(4) == 0) set_len(i, int'($urandom_range(6)));
            end
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (exp_done[i] && $urandom_range(1) == 0) bus.req[i] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
